// File: rtl/bp_pkg.sv
// Shared definitions for branch_target_predictor: index/tag width derivation,
// the saturating direction-counter step and the weakly-taken reset value.
package bp_pkg;

  localparam int unsigned PC_W      = 32;
  localparam int unsigned CTR_MAX_W = 4;

  // Index width for an ENTRIES-deep table
  function automatic int unsigned idx_w(input int unsigned entries);
    return $clog2(entries);
  endfunction

  // Tag width: PC bits above the index, word-aligned PC (bits [1:0] dropped)
  function automatic int unsigned tag_w(input int unsigned entries);
    return 30 - $clog2(entries);
  endfunction

  // Weakly-taken counter value 2^(bits-1)
  function automatic logic [CTR_MAX_W-1:0] ctr_weak_taken(input int unsigned bits);
    return CTR_MAX_W'(1 << (bits - 1));
  endfunction

  // Saturating up/down step; never wraps past 0 or 2^bits - 1
  function automatic logic [CTR_MAX_W-1:0] ctr_next(input logic [CTR_MAX_W-1:0] ctr,
                                                    input logic                 taken,
                                                    input int unsigned          bits);
    logic [CTR_MAX_W-1:0] max_v;
    max_v = CTR_MAX_W'((1 << bits) - 1);
    if (taken) begin
      return (ctr == max_v) ? ctr : ctr + 1'b1;
    end
    return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

endpackage

// File: rtl/bp_ghr.sv
// Non-speculative global history register: shifts in the resolved direction
// on every accepted branch update.
module bp_ghr #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         shift_i,
  input  logic         taken_i,
  output logic [W-1:0] ghr_o
);

  logic [W-1:0] ghr_q;
  logic [W-1:0] ghr_d;

  // Next history: shift left, newest outcome in bit 0
  always_comb begin
    ghr_d = ghr_q;
    if (shift_i) begin
      ghr_d = (ghr_q << 1) | W'(taken_i);
    end
  end

  // History register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign ghr_o = ghr_q;

endmodule

// File: rtl/branch_target_predictor.sv
// Parametrised BTB + direction predictor with registered, stallable lookup
// outputs and EX-stage resolved updates. Optional gshare PHT indexing is
// enabled by defining BP_GSHARE_EN.
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter  int unsigned ENTRIES  = 32,
  parameter  int unsigned CTR_BITS = 2,
  parameter  int unsigned GHR_BITS = 5,
  localparam int unsigned IDX_W    = idx_w(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_addr,
  input  logic             stall,
  input  logic             valid,
  input  logic             taken,
  input  logic [31:0]      ex_addr,
  input  logic [IDX_W-1:0] ex_pht_idx,
  input  logic [31:0]      target_addr,
  output logic             hit,
  output logic             prediction,
  output logic [31:0]      predicted_target,
  output logic [IDX_W-1:0] pht_idx
);

  localparam int unsigned TAG_W = tag_w(ENTRIES);

  // Reject unsupported configurations at elaboration
  if (ENTRIES < 4 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
    $error("ENTRIES must be a power of two >= 4");
  end
  if (CTR_BITS < 1 || CTR_BITS > CTR_MAX_W) begin : g_bad_ctr
    $error("CTR_BITS must be 1..4");
  end
  if (GHR_BITS < 1 || GHR_BITS > IDX_W) begin : g_bad_ghr
    $error("GHR_BITS must be 1..IDX_W");
  end

  logic [IDX_W-1:0] bidx, ex_bidx, pidx;
  logic [TAG_W-1:0] tag, ex_tag;

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [PC_W-1:0]     target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  logic                hit_q, pred_q;
  logic [PC_W-1:0]     tgt_q;
  logic [IDX_W-1:0]    pidx_q;
  logic                hit_d, pred_d;
  logic [PC_W-1:0]     tgt_d;
  logic [CTR_BITS-1:0] ctr_d;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_addr[1:0], ex_addr[1:0]};

  assign bidx    = pc_addr[IDX_W+1:2];
  assign tag     = pc_addr[31:IDX_W+2];
  assign ex_bidx = ex_addr[IDX_W+1:2];
  assign ex_tag  = ex_addr[31:IDX_W+2];

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr;

  bp_ghr #(.W(GHR_BITS)) u_ghr (
    .clk     (clk),
    .reset   (reset),
    .shift_i (valid),
    .taken_i (taken),
    .ghr_o   (ghr)
  );

  assign pidx = bidx ^ IDX_W'(ghr);
`else
  assign pidx = bidx;
`endif

  // Lookup result from current (pre-update) table contents
  always_comb begin
    hit_d  = valid_q[bidx] && (tag_q[bidx] == tag);
    pred_d = hit_d && ctr_q[pidx][CTR_BITS-1];
    tgt_d  = hit_d ? target_q[bidx] : '0;
    ctr_d  = CTR_BITS'(ctr_next(CTR_MAX_W'(ctr_q[ex_pht_idx]), taken, CTR_BITS));
  end

  // Registered lookup outputs, held while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q  <= 1'b0;
      pred_q <= 1'b0;
      tgt_q  <= '0;
      pidx_q <= '0;
    end else if (!stall) begin
      hit_q  <= hit_d;
      pred_q <= pred_d;
      tgt_q  <= tgt_d;
      pidx_q <= pidx;
    end
  end

  // Resolved-branch update of counters and BTB; independent of stall
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_BITS'(ctr_weak_taken(CTR_BITS));
      end
    end else if (valid) begin
      ctr_q[ex_pht_idx] <= ctr_d;
      if (taken) begin
        valid_q[ex_bidx]  <= 1'b1;
        tag_q[ex_bidx]    <= ex_tag;
        target_q[ex_bidx] <= target_addr;
      end
    end
  end

  assign hit              = hit_q;
  assign prediction       = pred_q;
  assign predicted_target = tgt_q;
  assign pht_idx          = pidx_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed self-checking bench for branch_target_predictor (default params).
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_addr;
  logic        stall;
  logic        valid;
  logic        taken;
  logic [31:0] ex_addr;
  logic [4:0]  ex_pht_idx;
  logic [31:0] target_addr;
  logic        hit;
  logic        prediction;
  logic [31:0] predicted_target;
  logic [4:0]  pht_idx;

  int unsigned vecs = 0;
  int unsigned errs = 0;
  logic [38:0] got_v, exp_v;

  branch_target_predictor #(.ENTRIES(32), .CTR_BITS(2), .GHR_BITS(5)) dut (
    .clk              (clk),
    .reset            (reset),
    .pc_addr          (pc_addr),
    .stall            (stall),
    .valid            (valid),
    .taken            (taken),
    .ex_addr          (ex_addr),
    .ex_pht_idx       (ex_pht_idx),
    .target_addr      (target_addr),
    .hit              (hit),
    .prediction       (prediction),
    .predicted_target (predicted_target),
    .pht_idx          (pht_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [38:0] pk(input logic h, input logic p,
                                     input logic [31:0] t, input logic [4:0] i);
    return {h, p, t, i};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [31:0] a, input logic [4:0] idx,
                           input logic tk, input logic [31:0] tgt);
    valid = 1'b1; taken = tk; ex_addr = a; ex_pht_idx = idx; target_addr = tgt;
    step();
    valid = 1'b0; taken = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] a);
    pc_addr = a;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; pc_addr = 32'h40;
    valid = 1'b1; taken = 1'b1; ex_addr = 32'h48; ex_pht_idx = 5'd18; target_addr = 32'h400;
    step(); step();
    got_v = {hit, prediction, predicted_target, pht_idx}; exp_v = '0; vecs++;
    if (got_v !== exp_v) begin errs++; $display("FAIL reset_outputs got=%h exp=%h", got_v, exp_v); end
    reset = 1'b0; valid = 1'b0; taken = 1'b0;
    do_lookup(32'h48);
    got_v = {hit, prediction, predicted_target, pht_idx}; exp_v = pk(0, 0, 0, 18); vecs++;
    if (got_v !== exp_v) begin errs++; $display("FAIL reset_drops_update got=%h exp=%h", got_v, exp_v); end
    do_lookup(32'h40);
    got_v = {hit, prediction, predicted_target, pht_idx}; exp_v = pk(0, 0, 0, 16); vecs++;
    if (got_v !== exp_v) begin errs++; $display("FAIL reset_lookup_40 got=%h exp=%h", got_v, exp_v); end
  endtask

  task automatic test_taken_update();
    do_update(32'h40, 5'd16, 1'b1, 32'h100);
    do_lookup(32'h40);
    got_v = {hit, prediction, predicted_target, pht_idx}; exp_v = pk(1, 1, 32'h100, 16); vecs++;
    if (got_v !== exp_v) begin errs++; $display("FAIL taken_install got=%h exp=%h", got_v, exp_v); end
  endtask

  task automatic test_not_taken();
    do_update(32'h40, 5'd16, 1'b0, 32'h0);
    do_update(32'h40, 5'd16, 1'b0, 32'h0);
    do_lookup(32'h40);
    got_v = {hit, prediction, predicted_target, pht_idx}; exp_v = pk(1, 0, 32'h100, 16); vecs++;
    if (got_v !== exp_v) begin errs++; $display("FAIL not_taken_pred got=%h exp=%h", got_v, exp_v); end
    do_lookup(32'hC0);
    got_v = {hit, prediction, predicted_target, pht_idx}; exp_v = pk(0, 0, 0, 16); vecs++;
    if (got_v !== exp_v) begin errs++; $display("FAIL alias_tag_miss got=%h exp=%h", got_v, exp_v); end
  endtask

  task automatic test_saturation();
    // counter starts at 1; five taken saturate at 3
    for (int i = 0; i < 5; i++) do_update(32'h40, 5'd16, 1'b1, 32'h100);
    do_lookup(32'h40);
    got_v = {hit, prediction, predicted_target, pht_idx}; exp_v = pk(1, 1, 32'h100, 16); vecs++;
    if (got_v !== exp_v) begin errs++; $display("FAIL sat_high got=%h exp=%h", got_v, exp_v); end
    // six not-taken: 2,1,0,0,0,0
    for (int k = 0; k < 6; k++) begin
      do_update(32'h40, 5'd16, 1'b0, 32'h0);
      do_lookup(32'h40);
      got_v = {hit, prediction, predicted_target, pht_idx};
      exp_v = pk(1, (k == 0), 32'h100, 16); vecs++;
      if (got_v !== exp_v) begin errs++; $display("FAIL sat_low_step%0d got=%h exp=%h", k, got_v, exp_v); end
    end
    // from 0 one taken gives 1 (no wrap to 3), second gives 2
    do_update(32'h40, 5'd16, 1'b1, 32'h100);
    do_lookup(32'h40);
    got_v = {hit, prediction, predicted_target, pht_idx}; exp_v = pk(1, 0, 32'h100, 16); vecs++;
    if (got_v !== exp_v) begin errs++; $display("FAIL no_wrap_1 got=%h exp=%h", got_v, exp_v); end
    do_update(32'h40, 5'd16, 1'b1, 32'h100);
    do_lookup(32'h40);
    got_v = {hit, prediction, predicted_target, pht_idx}; exp_v = pk(1, 1, 32'h100, 16); vecs++;
    if (got_v !== exp_v) begin errs++; $display("FAIL no_wrap_2 got=%h exp=%h", got_v, exp_v); end
  endtask

  task automatic test_same_edge();
    pc_addr = 32'h40;
    do_update(32'h40, 5'd16, 1'b1, 32'h200);
    got_v = {hit, prediction, predicted_target, pht_idx}; exp_v = pk(1, 1, 32'h100, 16); vecs++;
    if (got_v !== exp_v) begin errs++; $display("FAIL same_edge_old got=%h exp=%h", got_v, exp_v); end
    do_lookup(32'h40);
    got_v = {hit, prediction, predicted_target, pht_idx}; exp_v = pk(1, 1, 32'h200, 16); vecs++;
    if (got_v !== exp_v) begin errs++; $display("FAIL same_edge_new got=%h exp=%h", got_v, exp_v); end
  endtask

  task automatic test_stall();
    logic [31:0] pcs [3];
    pcs[0] = 32'hC0; pcs[1] = 32'h0; pcs[2] = 32'h44;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      pc_addr = pcs[c];
      if (c == 1) do_update(32'h44, 5'd17, 1'b1, 32'h300);
      else step();
      got_v = {hit, prediction, predicted_target, pht_idx}; exp_v = pk(1, 1, 32'h200, 16); vecs++;
      if (got_v !== exp_v) begin errs++; $display("FAIL stall_hold%0d got=%h exp=%h", c, got_v, exp_v); end
    end
    stall = 1'b0;
    do_lookup(32'h44);
    got_v = {hit, prediction, predicted_target, pht_idx}; exp_v = pk(1, 1, 32'h300, 17); vecs++;
    if (got_v !== exp_v) begin errs++; $display("FAIL stall_update got=%h exp=%h", got_v, exp_v); end
  endtask

  task automatic test_index_boundary();
    do_update(32'hFFFF_FFFC, 5'd31, 1'b1, 32'hDEAD_BEE0);
    do_lookup(32'hFFFF_FFFC);
    got_v = {hit, prediction, predicted_target, pht_idx}; exp_v = pk(1, 1, 32'hDEAD_BEE0, 31); vecs++;
    if (got_v !== exp_v) begin errs++; $display("FAIL top_entry got=%h exp=%h", got_v, exp_v); end
    do_lookup(32'hFFFF_FFFF);
    got_v = {hit, prediction, predicted_target, pht_idx}; exp_v = pk(1, 1, 32'hDEAD_BEE0, 31); vecs++;
    if (got_v !== exp_v) begin errs++; $display("FAIL low_bits_ignored got=%h exp=%h", got_v, exp_v); end
    do_lookup(32'h7C);
    got_v = {hit, prediction, predicted_target, pht_idx}; exp_v = pk(0, 0, 0, 31); vecs++;
    if (got_v !== exp_v) begin errs++; $display("FAIL top_tag0_miss got=%h exp=%h", got_v, exp_v); end
    do_lookup(32'h7FFF_FFFC);
    got_v = {hit, prediction, predicted_target, pht_idx}; exp_v = pk(0, 0, 0, 31); vecs++;
    if (got_v !== exp_v) begin errs++; $display("FAIL tag_msb_miss got=%h exp=%h", got_v, exp_v); end
  endtask

`ifdef BP_GSHARE_EN
  task automatic test_gshare();
    do_update(32'h40, 5'd16, 1'b1, 32'h100);
    do_update(32'h40, 5'd16, 1'b1, 32'h100);
    do_update(32'h40, 5'd16, 1'b0, 32'h0);
    do_lookup(32'h40);
    got_v = {hit, prediction, predicted_target, pht_idx}; exp_v = pk(1, 1, 32'h100, 22); vecs++;
    if (got_v !== exp_v) begin errs++; $display("FAIL gshare_idx got=%h exp=%h", got_v, exp_v); end
  endtask
`endif

  initial begin
    reset = 1'b1; pc_addr = '0; stall = 1'b0; valid = 1'b0; taken = 1'b0;
    ex_addr = '0; ex_pht_idx = '0; target_addr = '0;
    test_reset();
`ifdef BP_GSHARE_EN
    test_gshare();
`else
    test_taken_update();
    test_not_taken();
    test_saturation();
    test_same_edge();
    test_stall();
    test_index_boundary();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised branch target predictor for the 5-stage pipeline. The IF stage presents a fetch PC and receives a registered target prediction one cycle later. The EX stage writes back resolved branch outcomes. Compared with the fixed 32-entry predictor, this block adds:
- configurable depth and counter width
- per-entry valid bits
- hit decoupled from direction
- a lookup stall
- an optional gshare-indexed pattern history table (PHT)

## Interface
Parameters:
- ENTRIES, 32 — BTB and PHT depth; power of two, ≥ 4. IDX_W = log2(ENTRIES); TAG_W = 30 − IDX_W.
- CTR_BITS, 2 — saturating counter width, 1..4.
- GHR_BITS, 5 — global history length, 1..IDX_W. Used only when gshare is compiled in.

Ports:
- clk  in  1 — the single clock.
- reset  in  1 — synchronous, active-high reset.
- pc_addr  in  32 — fetch PC, sampled every non-stalled cycle.
- stall  in  1 — hold all lookup outputs.
- valid  in  1 — EX-stage resolved branch update.
- taken  in  1 — resolved direction.
- ex_addr  in  32 — PC of the resolved branch.
- ex_pht_idx  in  IDX_W — the pht_idx that was returned for this branch at fetch.
- target_addr  in  32 — resolved target.
- hit  out  1 — BTB tag match on a valid entry.
- prediction  out  1 — predict taken; asserted only when hit is 1.
- predicted_target  out  32 — BTB target when hit is 1, else 0.
- pht_idx  out  IDX_W — PHT index used for this lookup; the pipeline carries it to EX.

## Operation
- Address split:
  - bidx = pc[IDX_W+1:2]
  - tag = pc[31:IDX_W+2]
  - The same split applies to ex_addr.
- State held in the block:
  - ENTRIES × {valid bit, tag, target}
  - ENTRIES × CTR_BITS counters
  - GHR (GHR_BITS wide)
- Lookup, when stall is 0:
  - hit ← valid[bidx] && tag[bidx] == tag.
  - prediction ← hit && counter[pidx] MSB.
  - predicted_target ← hit ? target[bidx] : 0.
  - pht_idx ← pidx.
- Lookup, when stall is 1: all four outputs hold their values.
- Update, when valid is 1 (independent of stall):
  - Counter at ex_pht_idx: +1 if taken, −1 if not; saturates at 0 and at 2^CTR_BITS − 1.
  - If taken: write the BTB entry at the ex_addr index (valid = 1, tag, target_addr), overwriting any aliased entry.
  - If not taken: the BTB entry is left unchanged.
- PHT index:
  - pidx = bidx without the gshare macro.
  - pidx = bidx XOR zero-extended GHR with it.
- GHR is non-speculative: on each valid update, GHR ← {GHR[GHR_BITS−2:0], taken}.
- Width rules:
  - Counters never wrap.
  - The tag compare uses exactly TAG_W bits.
  - PC bits [1:0] are ignored.

## Timing
- Reset values:
  - hit, prediction, predicted_target, pht_idx = 0.
  - All valid bits = 0.
  - Tags and targets = 0.
  - Counters = 2^(CTR_BITS−1), i.e. weakly taken.
  - GHR = 0.
- Reset has priority over stall and valid. An update presented in the same cycle as reset is dropped.
- Lookup latency is 1 cycle: pc_addr sampled at edge N gives outputs visible after edge N.
- Update latency: an update sampled at edge N is visible to a lookup sampled at edge N+1.
- Lookup and update at the same index on the same edge: the lookup returns pre-update state (read-before-write). No bypass.
- GHR used by a lookup is the value before any same-edge update.
- No handshake; an update is accepted every cycle that valid is 1.

## Configuration
- BP_GSHARE_EN defined:
  - pidx = bidx ^ {{(IDX_W−GHR_BITS){0}}, GHR}.
  - The GHR register is present.
- BP_GSHARE_EN undefined:
  - pidx = bidx.
  - No GHR register.
  - ex_pht_idx is still used for the counter update; the pipeline feeds back pht_idx unchanged.

## Structure
- Package bp_pkg holds:
  - the IDX_W/TAG_W derivation function (clog2-based)
  - the saturating counter next-value function (ctr, taken, CTR_BITS)
  - the weakly-taken reset constant
- One sub-module, bp_ghr: a GHR shift register with synchronous reset. It is instantiated only under BP_GSHARE_EN.

## Test plan
All cases use defaults (ENTRIES=32, CTR_BITS=2) with BP_GSHARE_EN undefined unless noted.
- Reset, then lookup 0x0000_0040 → hit=0, prediction=0, predicted_target=0, pht_idx=16.
- Update valid=1, taken=1, ex_addr=0x40, ex_pht_idx=16, target 0x100; then lookup 0x40 → hit=1, prediction=1, target 0x100 (counter 2→3).
- Two not-taken updates to index 16 (counter 3→1); then lookup 0x40 → hit=1, prediction=0, target 0x100. Lookup 0xC0 (same index, tag 1) → hit=0, target 0.
- Five taken updates leave the counter at 3; then six not-taken updates leave it at 0 (no wrap). Lookup returns prediction=0 throughout the not-taken run once the counter is below 2.
- Same edge: lookup 0x40 with a taken update to 0x40 carrying target 0x200 → that cycle's output shows the old target 0x100; the next lookup shows 0x200. Stall=1 for 3 cycles → outputs frozen while pc_addr changes.
- With BP_GSHARE_EN: after taken, taken, not-taken updates, GHR=0b00110. Lookup 0x40 → pht_idx = 16 ^ 6 = 22.
